// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the four-requester round-robin arbiter.
// The selected index feeds a downstream 2-to-4 decoder.
package arbiter_pkg;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned IDX_W = 2;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Next priority position after idx, wrapping 3 -> 0.
   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
      return idx + IDX_W'(1);
   endfunction

endpackage

// File: rtl/arbiter_rr_4_pick.sv
// Combinational round-robin selector.
// Returns the first set request at or after ptr, modulo 4.
module rr_pick
   import arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [IDX_W-1:0] cand_s;

   // Scan from the farthest offset down so that the nearest requester wins.
   always_comb begin
      any    = |req;
      idx    = ptr;
      cand_s = ptr;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         cand_s = ptr + IDX_W'(i);
         if (req[cand_s]) begin
            idx = cand_s;
         end else begin
            idx = idx;
         end
      end
   end

endmodule

// File: rtl/arbiter_rr_4.sv
// Round-robin arbiter for four requesters with grant hold limit and timeout pulse.
// All outputs are registered; grant_idx drives a 2-to-4 decoder directly.
module arbiter_rr_4
   import arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 15
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             release_i,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid,
   output logic             timeout
);

   localparam int unsigned      HOLD_W    = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   state_t            state_r, state_s;
   logic [IDX_W-1:0]  ptr_r, ptr_s;
   logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
   logic [IDX_W-1:0]  grant_idx_r, grant_idx_s;
   logic              grant_valid_r, grant_valid_s;
   logic              timeout_r, timeout_s;

   logic [IDX_W-1:0]  pick_idx_s;
   logic              pick_any_s;
   logic              owner_req_s;
   logic              hold_limit_s;
   logic              exit_s;

   rr_pick u_pick (
      .req (req),
      .ptr (ptr_r),
      .idx (pick_idx_s),
      .any (pick_any_s)
   );

   // Exit causes for the current grant.
   always_comb begin
      owner_req_s  = req[grant_idx_r];
      hold_limit_s = (hold_cnt_r == HOLD_LAST);
      exit_s       = release_i | ~owner_req_s | hold_limit_s;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (pick_any_s) begin
               state_s = GRANT;
            end else begin
               state_s = IDLE;
            end
         end
         GRANT: begin
            if (exit_s) begin
               state_s = IDLE;
            end else begin
               state_s = GRANT;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Next values of pointer, hold counter and output registers.
   always_comb begin
      ptr_s         = ptr_r;
      hold_cnt_s    = hold_cnt_r;
      grant_idx_s   = grant_idx_r;
      grant_valid_s = 1'b0;
      timeout_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (pick_any_s) begin
               grant_idx_s   = pick_idx_s;
               hold_cnt_s    = {HOLD_W{1'b0}};
               grant_valid_s = 1'b1;
            end else begin
               grant_valid_s = 1'b0;
            end
         end
         GRANT: begin
            hold_cnt_s = hold_cnt_r + HOLD_W'(1);
            if (exit_s) begin
               ptr_s         = next_ptr(grant_idx_r);
               grant_valid_s = 1'b0;
               // Only a pure hold-limit expiry is reported as a timeout.
               timeout_s     = hold_limit_s & ~release_i & owner_req_s;
            end else begin
               grant_valid_s = 1'b1;
            end
         end
         default: begin
            ptr_s         = {IDX_W{1'b0}};
            hold_cnt_s    = {HOLD_W{1'b0}};
            grant_idx_s   = {IDX_W{1'b0}};
            grant_valid_s = 1'b0;
            timeout_s     = 1'b0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r         <= {IDX_W{1'b0}};
         hold_cnt_r    <= {HOLD_W{1'b0}};
         grant_idx_r   <= {IDX_W{1'b0}};
         grant_valid_r <= 1'b0;
         timeout_r     <= 1'b0;
      end else begin
         ptr_r         <= ptr_s;
         hold_cnt_r    <= hold_cnt_s;
         grant_idx_r   <= grant_idx_s;
         grant_valid_r <= grant_valid_s;
         timeout_r     <= timeout_s;
      end
   end

   assign grant_idx   = grant_idx_r;
   assign grant_valid = grant_valid_r;
   assign timeout     = timeout_r;

endmodule

// File: tb/tb_arbiter_rr_4.sv
// Directed bench for arbiter_rr_4: vector table plus hand sequences for
// hold-limit timeout, release at the limit and asynchronous reset.
module tb_arbiter_rr_4;

   typedef struct {
      logic [3:0] req;
      logic       rel;
      logic [1:0] idx;
      logic       valid;
      logic       to;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       release_i;
   logic [1:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   int n_checks;
   int n_fail;

   vec_t vecs[$];

   arbiter_rr_4 #(.MAX_HOLD(15)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .release_i   (release_i),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic [3:0] r, input logic rl, input logic [1:0] i,
                      input logic v, input logic t);
      vec_t e;
      e.req = r; e.rel = rl; e.idx = i; e.valid = v; e.to = t;
      vecs.push_back(e);
   endtask

   task automatic check(input string name, input logic [1:0] i, input logic v, input logic t);
      n_checks++;
      if (grant_idx !== i || grant_valid !== v || timeout !== t) begin
         n_fail++;
         $display("FAIL %s: got idx=%0d valid=%0b timeout=%0b, expected idx=%0d valid=%0b timeout=%0b",
                  name, grant_idx, grant_valid, timeout, i, v, t);
      end
   endtask

   task automatic step(input logic [3:0] r, input logic rl);
      req       = r;
      release_i = rl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      req       = 4'b0000;
      release_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset", 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Rotation 0,1,2,3,0 with release on each grant's first cycle.
      add(4'b1111, 1'b0, 2'd0, 1'b1, 1'b0);
      add(4'b1111, 1'b1, 2'd0, 1'b0, 1'b0);
      add(4'b1111, 1'b0, 2'd1, 1'b1, 1'b0);
      add(4'b1111, 1'b1, 2'd1, 1'b0, 1'b0);
      add(4'b1111, 1'b0, 2'd2, 1'b1, 1'b0);
      add(4'b1111, 1'b1, 2'd2, 1'b0, 1'b0);
      add(4'b1111, 1'b0, 2'd3, 1'b1, 1'b0);
      add(4'b1111, 1'b1, 2'd3, 1'b0, 1'b0);
      add(4'b1111, 1'b0, 2'd0, 1'b1, 1'b0);
      add(4'b1111, 1'b1, 2'd0, 1'b0, 1'b0);
      // Release in IDLE is ignored; grant goes to 1, then ptr=2.
      add(4'b1111, 1'b1, 2'd1, 1'b1, 1'b0);
      add(4'b1111, 1'b1, 2'd1, 1'b0, 1'b0);
      // ptr=2 with req=0011 wraps to 0, then ptr=1 picks 1.
      add(4'b0011, 1'b0, 2'd0, 1'b1, 1'b0);
      add(4'b0011, 1'b1, 2'd0, 1'b0, 1'b0);
      add(4'b0011, 1'b0, 2'd1, 1'b1, 1'b0);
      // Owner drop ends the grant; idle with no request keeps the index.
      add(4'b0000, 1'b0, 2'd1, 1'b0, 1'b0);
      add(4'b0000, 1'b0, 2'd1, 1'b0, 1'b0);
      // Owner 3 holds 4 cycles while others change, then drops with req[0]=1.
      add(4'b1000, 1'b0, 2'd3, 1'b1, 1'b0);
      add(4'b1001, 1'b0, 2'd3, 1'b1, 1'b0);
      add(4'b1011, 1'b0, 2'd3, 1'b1, 1'b0);
      add(4'b1001, 1'b0, 2'd3, 1'b1, 1'b0);
      add(4'b0001, 1'b0, 2'd3, 1'b0, 1'b0);
      add(4'b0001, 1'b0, 2'd0, 1'b1, 1'b0);
      add(4'b0001, 1'b1, 2'd0, 1'b0, 1'b0);

      for (int k = 0; k < vecs.size(); k++) begin
         step(vecs[k].req, vecs[k].rel);
         check($sformatf("vec%0d", k), vecs[k].idx, vecs[k].valid, vecs[k].to);
      end

      // Held request with no release: 15 valid cycles, timeout in the gap, regrant.
      for (int c = 1; c <= 15; c++) begin
         step(4'b0100, 1'b0);
         check($sformatf("hold_c%0d", c), 2'd2, 1'b1, 1'b0);
      end
      step(4'b0100, 1'b0);
      check("timeout_gap", 2'd2, 1'b0, 1'b1);
      step(4'b0100, 1'b0);
      check("regrant_after_timeout", 2'd2, 1'b1, 1'b0);

      // Release coinciding with the hold limit: no timeout pulse.
      for (int c = 2; c <= 15; c++) begin
         step(4'b0100, 1'b0);
         check($sformatf("hold2_c%0d", c), 2'd2, 1'b1, 1'b0);
      end
      step(4'b0100, 1'b1);
      check("release_at_limit", 2'd2, 1'b0, 1'b0);
      step(4'b0100, 1'b0);
      check("regrant_after_release", 2'd2, 1'b1, 1'b0);

      // Asynchronous reset between edges while granted.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      req   = 4'b1000;
      rst_n = 1'b1;
      step(4'b1000, 1'b0);
      check("grant_after_reset", 2'd3, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
